// File: rtl/modexp_pkg.sv
// Shared definitions for the modular exponentiation controller.
// Holds default sizes and the FSM state encoding.
package modexp_pkg;

  localparam int MODEXP_WIDTH  = 1024;
  localparam int MODEXP_ELEN_W = 11;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_TOMONT     = 4'd1;
  localparam logic [3:0] ST_TOMONT_W   = 4'd2;
  localparam logic [3:0] ST_SQ         = 4'd3;
  localparam logic [3:0] ST_SQ_W       = 4'd4;
  localparam logic [3:0] ST_MUL        = 4'd5;
  localparam logic [3:0] ST_MUL_W      = 4'd6;
  localparam logic [3:0] ST_FROMMONT   = 4'd7;
  localparam logic [3:0] ST_FROMMONT_W = 4'd8;
  localparam logic [3:0] ST_DONE       = 4'd9;

  typedef enum logic [3:0] {
    IDLE       = ST_IDLE,
    TOMONT     = ST_TOMONT,
    TOMONT_W   = ST_TOMONT_W,
    SQ         = ST_SQ,
    SQ_W       = ST_SQ_W,
    MUL        = ST_MUL,
    MUL_W      = ST_MUL_W,
    FROMMONT   = ST_FROMMONT,
    FROMMONT_W = ST_FROMMONT_W,
    DONE       = ST_DONE
  } state_e;

  function automatic logic is_issue(state_e s);
    return (s == TOMONT) || (s == SQ) ||
           (s == MUL) || (s == FROMMONT);
  endfunction

endpackage

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an
// external Montgomery multiplier through the mm_* ports.
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int WIDTH  = MODEXP_WIDTH,
  parameter int ELEN_W = MODEXP_ELEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  in_x,
  input  logic [WIDTH-1:0]  in_e,
  input  logic [ELEN_W-1:0] in_e_len,
  input  logic [WIDTH-1:0]  in_m,
  input  logic [WIDTH-1:0]  in_r,
  input  logic [WIDTH-1:0]  in_r2,
  output logic              mm_start,
  output logic [WIDTH-1:0]  mm_a,
  output logic [WIDTH-1:0]  mm_b,
  output logic [WIDTH-1:0]  mm_m,
  input  logic [WIDTH-1:0]  mm_result,
  input  logic              mm_done,
  output logic [WIDTH-1:0]  result,
  output logic              done
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [ELEN_W-1:0] LEN_MAX = ELEN_W'(WIDTH);
  localparam logic [ELEN_W-1:0] ONE_L   = ELEN_W'(1);

  state_e state_q, state_d;

  logic [WIDTH-1:0]  x_q, x_d, e_q, e_d;
  logic [WIDTH-1:0]  m_q, m_d, r_q, r_d;
  logic [WIDTH-1:0]  r2_q, r2_d;
  logic [WIDTH-1:0]  a_q, a_d, xm_q, xm_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [ELEN_W-1:0] len_q, len_d, i_q, i_d;
  logic              mm_start_q, done_q;
  logic              ebit;
  logic [ELEN_W-1:0] len_c;

  assign ebit  = e_q[i_q[IW-1:0]];
  assign len_c = (in_e_len > LEN_MAX) ? LEN_MAX : in_e_len;

  // Next-state and datapath update decisions.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    e_d     = e_q;
    m_d     = m_q;
    r_d     = r_q;
    r2_d    = r2_q;
    len_d   = len_q;
    i_d     = i_q;
    a_d     = a_q;
    xm_d    = xm_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = in_x;
          e_d     = in_e;
          m_d     = in_m;
          r_d     = in_r;
          r2_d    = in_r2;
          len_d   = len_c;
          i_d     = '0;
          state_d = TOMONT;
        end
      end
      TOMONT:   state_d = TOMONT_W;
      TOMONT_W: begin
        if (mm_done) begin
          xm_d = mm_result;
          a_d  = r_q;
          if (len_q != '0) begin
            i_d     = len_q - ONE_L;
            state_d = SQ;
          end else begin
            state_d = FROMMONT;
          end
        end
      end
      SQ:   state_d = SQ_W;
      SQ_W: begin
        if (mm_done) begin
          a_d = mm_result;
          if (ebit) begin
            state_d = MUL;
          end else if (i_q == '0) begin
            state_d = FROMMONT;
          end else begin
            i_d     = i_q - ONE_L;
            state_d = SQ;
          end
        end
      end
      MUL:   state_d = MUL_W;
      MUL_W: begin
        if (mm_done) begin
          a_d = mm_result;
          if (i_q == '0) begin
            state_d = FROMMONT;
          end else begin
            i_d     = i_q - ONE_L;
            state_d = SQ;
          end
        end
      end
      FROMMONT:   state_d = FROMMONT_W;
      FROMMONT_W: begin
        if (mm_done) begin
          res_d   = mm_result;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand select follows the state so it holds until mm_done.
  always_comb begin
    mm_a = a_q;
    mm_b = a_q;
    unique case (state_q)
      TOMONT, TOMONT_W: begin
        mm_a = x_q;
        mm_b = r2_q;
      end
      MUL, MUL_W:           mm_b = xm_q;
      FROMMONT, FROMMONT_W: mm_b = WIDTH'(1);
      default: ;
    endcase
  end

  // State, captured operands and registered pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      e_q        <= '0;
      m_q        <= '0;
      r_q        <= '0;
      r2_q       <= '0;
      len_q      <= '0;
      i_q        <= '0;
      a_q        <= '0;
      xm_q       <= '0;
      res_q      <= '0;
      mm_start_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      e_q        <= e_d;
      m_q        <= m_d;
      r_q        <= r_d;
      r2_q       <= r2_d;
      len_q      <= len_d;
      i_q        <= i_d;
      a_q        <= a_d;
      xm_q       <= xm_d;
      res_q      <= res_d;
      mm_start_q <= is_issue(state_d);
      done_q     <= (state_d == DONE);
    end
  end

  assign mm_start = mm_start_q;
  assign mm_m     = m_q;
  assign result   = res_q;
  assign done     = done_q;

endmodule

// File: doc/modexp_ctrl.md
MODEXP_CTRL -- requirements
Module: modexp_ctrl

Interface
REQ-001 Parameter WIDTH, default 1024: operand/modulus width in bits.
REQ-002 Parameter ELEN_W, default 11: width of the exponent-length field (holds 0..WIDTH).
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle request; sampled only in IDLE.
REQ-006 in_x  in  WIDTH  base, normal domain, < in_m.
REQ-007 in_e  in  WIDTH  exponent.
REQ-008 in_e_len  in  ELEN_W  number of exponent bits to process, 0..WIDTH.
REQ-009 in_m  in  WIDTH  odd modulus.
REQ-010 in_r  in  WIDTH  2^WIDTH mod in_m (Montgomery one).
REQ-011 in_r2  in  WIDTH  2^(2*WIDTH) mod in_m.
REQ-012 mm_start  out  1  one-cycle request pulse to the external Montgomery multiplier.
REQ-013 mm_a, mm_b, mm_m  out  WIDTH each  multiplier operands.
REQ-014 mm_result  in  WIDTH  multiplier result, valid when mm_done is high.
REQ-015 mm_done  in  1  multiplier completion pulse.
REQ-016 result  out  WIDTH  in_x^in_e[in_e_len-1:0] mod in_m.
REQ-017 done  out  1  one-cycle completion pulse.

Function
REQ-018 On start in IDLE, capture in_x, in_e, in_e_len, in_m, in_r, in_r2 into internal registers; later input changes have no effect.
REQ-019 Algorithm: Xm=MM(x,R2); A=R; for i=e_len-1 down to 0 { A=MM(A,A); if e[i], A=MM(A,Xm) }; result=MM(A,1). MM is one multiplier transaction.
REQ-020 States: IDLE, TOMONT, TOMONT_W, SQ, SQ_W, MUL, MUL_W, FROMMONT, FROMMONT_W, DONE.
REQ-021 Transitions: IDLE-start->TOMONT; each issue state->its _W state after one cycle; TOMONT_W/SQ_W/MUL_W/FROMMONT_W leave only on mm_done.
REQ-022 TOMONT_W exit: SQ if e_len>0, else FROMMONT.
REQ-023 SQ_W exit: MUL if e[i]=1; otherwise FROMMONT if i=0, else decrement i and go to SQ.
REQ-024 MUL_W exit: FROMMONT if i=0, else decrement i and go to SQ.
REQ-025 FROMMONT_W exit: DONE; DONE -> IDLE after one cycle.
REQ-026 mm_start is registered and high for exactly the one cycle spent in each issue state (TOMONT, SQ, MUL, FROMMONT).
REQ-027 mm_a/mm_b/mm_m are valid in the mm_start cycle and held stable until the matching mm_done.
REQ-028 Operands: TOMONT=(x,R2); SQ=(A,A); MUL=(A,Xm); FROMMONT=(A,1); mm_m=m always.
REQ-029 In the mm_done cycle, register mm_result into Xm (TOMONT_W), A (SQ_W, MUL_W) or result (FROMMONT_W).
REQ-030 done is high for the single cycle in DONE, with result already valid; result holds until the next accepted start.
REQ-031 Transaction count = 2 + e_len + popcount(e[e_len-1:0]).
REQ-032 Exponent bit e[i] is selected by a 1-of-WIDTH mux on index counter i; no barrel shift.
REQ-033 Ignore start outside IDLE.
REQ-034 Ignore mm_done outside _W states.
REQ-035 in_e_len > WIDTH is clamped to WIDTH.

Reset
REQ-036 While reset is high: state=IDLE; mm_start=0, done=0, result=0; A, Xm, i and the captured registers=0.
REQ-037 Reset mid-operation aborts immediately; no done pulse follows, and a later mm_done is ignored.

Structure
REQ-038 WIDTH, ELEN_W defaults and the state encoding (4-bit localparams) live in the shared modexp package.
REQ-039 No sub-module is instantiated; the Montgomery multiplier stays outside, connected through the mm_* ports.

Verification
REQ-040 Bench uses a behavioural MM model (variable latency 3-40 cycles), WIDTH=1024, m=2^1024-105 (odd), and bench-computed r and r2.
REQ-041 x=3, e=5, e_len=3 -> result=243, done pulse once, exactly 7 mm_start pulses.
REQ-042 x=7, e=anything, e_len=0 -> result=1, exactly 2 mm_start pulses.
REQ-043 x=2, e=0, e_len=1 -> result=1, 3 mm_start pulses; mm_a/mm_b never change between mm_start and mm_done.
REQ-044 start re-asserted every cycle during a run, plus a spurious mm_done in IDLE -> single run, result unchanged, no extra mm_start.
REQ-045 reset asserted during SQ_W of the x=3/e=5 run -> IDLE next cycle, done stays 0, result=0; a fresh start then yields 243.
